// File: rtl/aes256_round_key_store_if.sv
// Bus between the AES-256 key schedule producer / round datapath and the round key store.
interface aes256_round_key_store_if #(
    parameter int RK_W = 128,
    parameter int AW   = 4
) ();
    logic            key_start;
    logic [RK_W-1:0] rk_in;
    logic            rk_in_valid;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [RK_W-1:0] rd_data;
    logic            rd_valid;
    logic            rd_err;
    logic            keys_ready;
    logic [AW-1:0]   load_count;
    logic            overflow;

    modport master (
        output key_start, rk_in, rk_in_valid, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_err, keys_ready, load_count, overflow
    );

    modport slave (
        input  key_start, rk_in, rk_in_valid, rd_en, rd_addr,
        output rd_data, rd_valid, rd_err, keys_ready, load_count, overflow
    );
endinterface

// File: rtl/aes256_round_key_store.sv
// Captures the 15 AES-256 round keys and serves 1-cycle registered reads gated by load progress.
// Optional ROUND_KEY_ZEROIZE_EN: reset and key_start also clear every stored entry.
module aes256_round_key_store #(
    parameter int NUM_RK = 15,
    parameter int RK_W   = 128,
    parameter int AW     = 4
) (
    input logic                     clk,
    input logic                     rst,
    aes256_round_key_store_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_RK - 1);

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_load_count;
    logic            r_keys_ready;
    logic            r_overflow;
    logic [RK_W-1:0] r_rd_data;
    logic            r_rd_valid;
    logic            r_rd_err;
    logic [RK_W-1:0] r_mem [NUM_RK];

    logic              w_wr_en;
    logic [NUM_RK-1:0] w_entry_we;

    // key_start wins over a coincident rk_in_valid, so its data never lands.
    assign w_wr_en = (r_state == LOAD) && bus.rk_in_valid && !bus.key_start;

    for (genvar gi = 0; gi < NUM_RK; gi++) begin : g_we
        assign w_entry_we[gi] = w_wr_en && (r_wr_ptr == AW'(gi));
    end

`ifdef ROUND_KEY_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (!rst || bus.key_start) begin
            for (int i = 0; i < NUM_RK; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RK; i++) begin
                if (w_entry_we[i]) begin
                    r_mem[i] <= bus.rk_in;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RK; i++) begin
                if (w_entry_we[i]) begin
                    r_mem[i] <= bus.rk_in;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_load_count <= '0;
            r_keys_ready <= 1'b0;
            r_overflow   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_err     <= 1'b0;
        end else begin
            if (bus.key_start) begin
                r_state      <= LOAD;
                r_wr_ptr     <= '0;
                r_load_count <= '0;
                r_keys_ready <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    LOAD: begin
                        if (bus.rk_in_valid) begin
                            r_load_count <= r_load_count + 1'b1;
                            // Pointer parks on the last entry; the state change stops further writes.
                            if (r_wr_ptr == LAST_IDX) begin
                                r_state <= READY;
                            end else begin
                                r_wr_ptr <= r_wr_ptr + 1'b1;
                            end
                        end
                    end
                    READY: begin
                        r_keys_ready <= 1'b1;
                        if (bus.rk_in_valid) begin
                            r_overflow <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end

            // load_count never exceeds NUM_RK, so this also rejects out-of-range addresses.
            if (bus.rd_en) begin
                if (bus.rd_addr < r_load_count) begin
                    r_rd_data  <= r_mem[bus.rd_addr];
                    r_rd_valid <= 1'b1;
                    r_rd_err   <= 1'b0;
                end else begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                    r_rd_err   <= 1'b1;
                end
            end else begin
                r_rd_valid <= 1'b0;
                r_rd_err   <= 1'b0;
            end
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_err     = r_rd_err;
    assign bus.keys_ready = r_keys_ready;
    assign bus.load_count = r_load_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: doc/aes256_round_key_store.md
Name: aes256_round_key_store

Overview:
- Sits directly downstream of keyexpansion and captures the 15 AES-256 round keys it produces on out_key, one per valid cycle.
- Holds them in a register file and serves random-access, 1-cycle-latency reads to the AES round datapath of the CTR core.
- Tracks load progress and flags protocol errors, so the cipher only starts once the full schedule is resident.

Parameters:
- NUM_RK, 15, number of round keys stored (AES-256: rounds 0..14)
- RK_W, 128, round key width in bits
- AW, 4, address width for write pointer and read address

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- key_start  input  1  pulse: new key schedule begins; restarts loading
- rk_in  input  RK_W  round key from keyexpansion out_key
- rk_in_valid  input  1  rk_in holds the next round key in sequence
- rd_en  input  1  read request
- rd_addr  input  AW  round index to read
- rd_data  output  RK_W  read data, valid when rd_valid=1
- rd_valid  output  1  read completed with a loaded entry
- rd_err  output  1  read to an unloaded or out-of-range entry
- keys_ready  output  1  all NUM_RK keys of the current schedule loaded
- load_count  output  AW  number of keys loaded for current schedule (0..15)
- overflow  output  1  sticky: rk_in_valid received while in READY

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; load_count=0; wr_ptr=0.
  - rd_data=0, rd_valid=0, rd_err=0, keys_ready=0, overflow=0.
  - Storage contents are not cleared, unless ROUND_KEY_ZEROIZE_EN is defined.
  - Reset asserted mid-load aborts the load immediately.
- States:
  - IDLE: waits for key_start. rk_in_valid is ignored and does not set overflow.
  - LOAD: entered on key_start. wr_ptr=0, load_count=0, keys_ready=0, overflow cleared.
    - Each cycle with rk_in_valid=1 writes rk_in to entry wr_ptr, then wr_ptr++ and load_count++.
    - The write of entry NUM_RK-1 moves to READY; keys_ready=1 on the following cycle, with load_count=15.
  - READY: holds the schedule. rk_in_valid=1 sets overflow (sticky) and does not write storage.
- key_start in any state, including LOAD and READY:
  - Restarts LOAD.
  - Takes priority over a coincident rk_in_valid, whose data is discarded that cycle.
  - Takes effect on the next edge: keys_ready and load_count drop to 0 one cycle after key_start.
- Load latency: with rk_in_valid held high from the cycle after key_start, keys_ready rises 16 cycles after the key_start cycle. Gaps in rk_in_valid stall loading with no timeout.
- Reads, registered with 1-cycle latency. rd_en sampled at edge N gives outputs at edge N+1:
  - If rd_addr < load_count (as sampled at edge N): rd_data=entry, rd_valid=1, rd_err=0.
  - If rd_addr >= load_count, or rd_addr > NUM_RK-1: rd_valid=0, rd_err=1, rd_data=0.
  - If rd_en=0: rd_valid=0, rd_err=0, rd_data holds its last value.
- Same-cycle write and read of the same address: the read returns the old contents and is flagged rd_err, because load_count has not yet advanced.
- Reads are permitted during LOAD for entries already loaded. The cipher may begin round 0 before keys_ready.
- No arithmetic wrap: wr_ptr never exceeds NUM_RK-1. load_count saturates at NUM_RK.

Optional Feature:
- Macro ROUND_KEY_ZEROIZE_EN.
- Defined:
  - Reset and key_start both clear all NUM_RK entries to 0 in the same edge as the state change.
  - Any read of a stale entry from a previous key is impossible by construction; rd_data after zeroize reads 0.
- Not defined:
  - Entries keep previous-schedule contents until overwritten.
  - Access is still gated by load_count/rd_err.

Test Plan:
- Reset, then key_start. Stream the 15 round keys for key 642423ba...9c9b5a30, rk_in_valid continuous -> keys_ready=1 exactly 16 cycles after key_start; load_count=15; overflow=0.
- After load, rd_en with rd_addr=0 and then 1 -> next cycle rd_data=642423baa95efb4362d3f2ce993c0904, then 150f258aa1fe796841d7b4429c9b5a30; rd_valid=1, rd_err=0.
- Read rd_addr=15, then mid-load (load_count=3) read rd_addr=5 -> rd_err=1, rd_valid=0, rd_data=0 for both.
- In READY, pulse rk_in_valid with rk_in=all-ones -> overflow=1 and stays set; reading entry 14 still returns the original value. A following key_start clears overflow.
- key_start coincident with rk_in_valid at load_count=7 -> that data is discarded; load_count=0 next cycle; keys_ready=0; reload completes normally.
- rst=0 at load_count=9 -> all outputs 0 next cycle. With ROUND_KEY_ZEROIZE_EN defined, key_start followed by a read of addr 0 after one write gives the new key; without the macro, the same check applies and stale entries 1..14 are rejected via rd_err.
